itype_branch_map: RTL
=====================

ITYPE_BRANCH_MAP -- requirements
Module: itype_branch_map

Interface
REQ-001 Parameter MAP_LEN, default 31, SHALL set the maximum number of branch outcomes held in one map.
REQ-002 Parameter CNT_W, default $clog2(MAP_LEN+1), SHALL set the width of the branch counter.
REQ-003 The block SHALL have one clock, and its reset SHALL be asynchronous and active-low.
REQ-004 clk_i  input  1  clock; all state SHALL update on its rising edge.
REQ-005 rst_ni  input  1  asynchronous active-low reset.
REQ-006 valid_i  input  1  an itype beat is presented.
REQ-007 itype_i  input  mure_pkg::itype_e  the instruction type of the beat.
REQ-008 ready_o  output  1  the block accepts the beat this cycle.
REQ-009 flush_i  input  1  external request to emit the map held so far.
REQ-010 out_valid_o  output  1  the emitted map is valid.
REQ-011 out_ready_i  input  1  the downstream packet emitter consumes the map.
REQ-012 map_o  output  MAP_LEN  branch map; bit i = outcome of branch i (1 = not taken, 0 = taken).
REQ-013 branches_o  output  CNT_W  number of valid bits in map_o.
REQ-014 cause_o  output  2  emit cause: 1 = FULL, 2 = DISC, 3 = FLUSH; 0 when idle.

Function
REQ-015 The block SHALL have two states: COLLECT and EMIT.
REQ-016 ready_o SHALL be 1 in COLLECT and 0 in EMIT, decoded from state only.
REQ-017 out_valid_o SHALL be 1 in EMIT and 0 in COLLECT, decoded from state only.
REQ-018 A beat SHALL be accepted only when valid_i and ready_o are both 1.
REQ-019 An accepted NTB SHALL write 1 at map bit [count] and increment count by 1.
REQ-020 An accepted TB SHALL write 0 at map bit [count] and increment count by 1.
REQ-021 An accepted STD SHALL leave the map and count unchanged.
REQ-022 An accepted EXC, INT, ERET or UIJ with count > 0 SHALL move to EMIT with cause DISC; that beat SHALL NOT be added to the map.
REQ-023 An accepted EXC, INT, ERET or UIJ with count = 0 SHALL have no effect.
REQ-024 When an accepted branch makes count equal MAP_LEN, the next state SHALL be EMIT with cause FULL.
REQ-025 flush_i in COLLECT SHALL move to EMIT with cause FLUSH when count > 0, after any branch accepted in the same cycle is included.
REQ-026 flush_i in COLLECT with count = 0 and no branch accepted in the same cycle SHALL be ignored.
REQ-027 If FULL and FLUSH coincide, cause SHALL be FULL.
REQ-028 If DISC and flush_i coincide, cause SHALL be DISC.
REQ-029 out_valid_o SHALL rise on the cycle after the triggering beat (latency 1).
REQ-030 While in EMIT, map_o, branches_o and cause_o SHALL be held stable.
REQ-031 flush_i SHALL be ignored while in EMIT.
REQ-032 When out_valid_o and out_ready_i are both 1, the map, count and cause SHALL clear to 0 and the state SHALL return to COLLECT on the next cycle.
REQ-033 Map bits at index >= branches_o SHALL read as 0.
REQ-034 The count SHALL never exceed MAP_LEN and SHALL never wrap.

Reset
REQ-035 While rst_ni = 0, the state SHALL be COLLECT.
REQ-036 While rst_ni = 0, map_o, branches_o and cause_o SHALL be 0.
REQ-037 While rst_ni = 0, out_valid_o SHALL be 0 and ready_o SHALL be 1.
REQ-038 Reset asserted mid-operation, including in EMIT, SHALL discard the held map immediately.

Verification
REQ-039 The bench SHALL cover: beats NTB, TB, NTB, then ERET -> next cycle out_valid_o = 1, map_o[2:0] = 3'b101, branches_o = 3, cause_o = 2.
REQ-040 The bench SHALL cover: 31 consecutive TB beats with out_ready_i = 0 -> out_valid_o = 1, map_o = 0, branches_o = 31, cause_o = 1, ready_o = 0 held; then out_ready_i = 1 -> COLLECT with count 0.
REQ-041 The bench SHALL cover: NTB accepted together with flush_i at count 0 -> map_o[0] = 1, branches_o = 1, cause_o = 3.
REQ-042 The bench SHALL cover: EXC at count 0, then flush_i at count 0 -> out_valid_o stays 0 and all outputs stay 0.
REQ-043 The bench SHALL cover: rst_ni pulsed low while in EMIT holding 5 branches -> out_valid_o = 0, branches_o = 0, ready_o = 1 immediately, with no map emitted.

Source files
------------

// File: rtl/mure_pkg.sv
// Shared instruction-type encoding for the trace encoder blocks.
// Values follow the usual trace itype numbering, so new code points can be added later.
package mure_pkg;

    typedef enum logic [2:0] {
        ITYPE_STD  = 3'd0,
        ITYPE_EXC  = 3'd1,
        ITYPE_INT  = 3'd2,
        ITYPE_ERET = 3'd3,
        ITYPE_NTB  = 3'd4,
        ITYPE_TB   = 3'd5,
        ITYPE_UIJ  = 3'd6,
        ITYPE_RSVD = 3'd7
    } itype_e;

endpackage

// File: rtl/itype_branch_map_if.sv
// Handshake bundle between the itype source, the branch-map collector and the packet emitter.
interface itype_branch_map_if #(
    parameter int MAP_LEN = 31,
    parameter int CNT_W   = $clog2(MAP_LEN + 1)
);
    logic                 valid_i;
    mure_pkg::itype_e     itype_i;
    logic                 ready_o;
    logic                 flush_i;
    logic                 out_valid_o;
    logic                 out_ready_i;
    logic [MAP_LEN-1:0]   map_o;
    logic [CNT_W-1:0]     branches_o;
    logic [1:0]           cause_o;

    modport master (
        output valid_i, itype_i, flush_i, out_ready_i,
        input  ready_o, out_valid_o, map_o, branches_o, cause_o
    );

    modport slave (
        input  valid_i, itype_i, flush_i, out_ready_i,
        output ready_o, out_valid_o, map_o, branches_o, cause_o
    );
endinterface

// File: rtl/itype_branch_map.sv
// Collects branch outcomes from the itype stream into a map and hands the map
// to the packet emitter when it fills, on a discontinuity, or on a flush.
module itype_branch_map #(
    parameter int MAP_LEN = 31,
    parameter int CNT_W   = $clog2(MAP_LEN + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    itype_branch_map_if.slave   bus
);
    import mure_pkg::*;

    localparam logic [1:0] CAUSE_NONE  = 2'd0;
    localparam logic [1:0] CAUSE_FULL  = 2'd1;
    localparam logic [1:0] CAUSE_DISC  = 2'd2;
    localparam logic [1:0] CAUSE_FLUSH = 2'd3;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAP_LEN);

    typedef enum logic {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [MAP_LEN-1:0] map_q,   map_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [1:0]         cause_q, cause_d;

    logic is_ntb;
    logic is_tb;
    logic is_branch;
    logic is_disc;

    // Beats are only accepted in COLLECT, so qualify decode with the state.
    always_comb begin
        is_ntb  = 1'b0;
        is_tb   = 1'b0;
        is_disc = 1'b0;
        if (bus.valid_i && (state_q == COLLECT)) begin
            unique case (bus.itype_i)
                ITYPE_NTB:  is_ntb  = 1'b1;
                ITYPE_TB:   is_tb   = 1'b1;
                ITYPE_EXC,
                ITYPE_INT,
                ITYPE_ERET,
                ITYPE_UIJ:  is_disc = 1'b1;
                default:    ;
            endcase
        end
        is_branch = is_ntb || is_tb;
    end

    always_comb begin
        state_d = state_q;
        map_d   = map_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;

        unique case (state_q)
            COLLECT: begin
                // count stays below MAP_LEN here: reaching it always leaves COLLECT.
                if (is_branch) begin
                    for (int i = 0; i < MAP_LEN; i++) begin
                        if (cnt_q == CNT_W'(i)) begin
                            map_d[i] = is_ntb;
                        end
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                end

                if (is_disc && (cnt_q != '0)) begin
                    state_d = EMIT;
                    cause_d = CAUSE_DISC;
                end else if (is_branch && (cnt_d == CNT_MAX)) begin
                    state_d = EMIT;
                    cause_d = CAUSE_FULL;
                end else if (bus.flush_i && (cnt_d != '0)) begin
                    state_d = EMIT;
                    cause_d = CAUSE_FLUSH;
                end
            end

            EMIT: begin
                if (bus.out_ready_i) begin
                    state_d = COLLECT;
                    map_d   = '0;
                    cnt_d   = '0;
                    cause_d = CAUSE_NONE;
                end
            end

            default: begin
                state_d = COLLECT;
                map_d   = '0;
                cnt_d   = '0;
                cause_d = CAUSE_NONE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= COLLECT;
            map_q   <= '0;
            cnt_q   <= '0;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            map_q   <= map_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
        end
    end

    assign bus.ready_o     = (state_q == COLLECT);
    assign bus.out_valid_o = (state_q == EMIT);
    assign bus.map_o       = map_q;
    assign bus.branches_o  = cnt_q;
    assign bus.cause_o     = cause_q;

endmodule
